// File: rtl/stage_3_mc_exec.sv
// Multi-cycle execute stage: RV32I ALU, branch comparator and address unit, plus an
// iterative M-extension multiplier/divider, all behind a registered valid/ready output.
module stage_3_mc_exec #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 5,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Flush,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [XLEN-1:0]  PC_EX,
  input  logic [XLEN-1:0]  Operand1_ACU,
  input  logic [XLEN-1:0]  Operand2_ACU,
  input  logic [XLEN-1:0]  Operand1_DEU,
  input  logic [XLEN-1:0]  Operand2_DEU,
  input  logic [4:0]       Alu_Ctrl,
  input  logic             J_Type,
  input  logic             I_Type_JAL_R,
  input  logic [TAG_W-1:0] Rd_Tag,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [XLEN-1:0]  Alu_Out,
  output logic [XLEN-1:0]  Address_Out,
  output logic             Is_Branch_Taken,
  output logic [XLEN-1:0]  PC_Out,
  output logic [TAG_W-1:0] Rd_Tag_Out,
  output logic             Busy
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       state_reg;
  logic [SHW-1:0]   cnt_reg;
  logic [XLEN-1:0]  hi_reg, lo_reg, b_reg;
  logic             neg_reg, rneg_reg;
  logic [1:0]       op_reg;
  logic             out_valid_reg, taken_reg;
  logic [XLEN-1:0]  alu_out_reg, addr_reg, pc_reg;
  logic [TAG_W-1:0] tag_reg;

  logic [XLEN-1:0] op1, op2, single_res, special_res, mag1, mag2, addr_sum;
  logic [SHW-1:0]  shamt;
  logic            single_taken, accept, is_m, is_div, special;
  logic            div_signed, div_zero, div_ovf, s1, s2, neg1, neg2;

  assign op1   = Operand1_DEU;
  assign op2   = Operand2_DEU;
  assign shamt = Operand2_DEU[SHW-1:0];

  assign In_Ready = (state_reg == ST_IDLE) && (!out_valid_reg || Out_Ready) && !Flush;
  assign accept   = In_Valid && In_Ready;
  assign Busy     = (state_reg != ST_IDLE);

  assign is_m       = ENABLE_M && (Alu_Ctrl[4:3] == 2'b11);
  assign is_div     = is_m && Alu_Ctrl[2];
  assign div_signed = !Alu_Ctrl[0];
  assign div_zero   = (op2 == '0);
  assign div_ovf    = div_signed && (op1 == MIN_NEG) && (op2 == '1);
  assign special    = is_div && (div_zero || div_ovf);

  // Divide-by-zero takes precedence; overflow only applies with a nonzero divisor.
  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = Alu_Ctrl[1] ? op1 : '1;
    else if (!Alu_Ctrl[1])
      special_res = op1;
  end

  // Operand signedness: MUL/MULH/DIV/REM signed x signed, MULHSU signed x unsigned.
  assign s1   = is_div ? div_signed : (Alu_Ctrl[1:0] != 2'b11);
  assign s2   = is_div ? div_signed : !Alu_Ctrl[1];
  assign neg1 = s1 && op1[XLEN-1];
  assign neg2 = s2 && op2[XLEN-1];
  assign mag1 = neg1 ? -op1 : op1;
  assign mag2 = neg2 ? -op2 : op2;

  assign addr_sum = Operand1_ACU + Operand2_ACU;

  always_comb begin
    single_res   = '0;
    single_taken = 1'b0;
    case (Alu_Ctrl)
      5'b00000: single_res = op1 + op2;
      5'b01000: single_res = op1 - op2;
      5'b00001: single_res = op1 << shamt;
      5'b00010: single_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      5'b00011: single_res = {{(XLEN-1){1'b0}}, op1 < op2};
      5'b00100: single_res = op1 ^ op2;
      5'b00101: single_res = op1 >> shamt;
      5'b01101: single_res = $signed(op1) >>> shamt;
      5'b00110: single_res = op1 | op2;
      5'b00111: single_res = op1 & op2;
      5'b10000: single_taken = (op1 == op2);
      5'b10001: single_taken = (op1 != op2);
      5'b10100: single_taken = ($signed(op1) < $signed(op2));
      5'b10101: single_taken = !($signed(op1) < $signed(op2));
      5'b10110: single_taken = (op1 < op2);
      5'b10111: single_taken = !(op1 < op2);
      default: begin
        if (is_m)
          single_res = special_res;
        else
          single_taken = J_Type | I_Type_JAL_R;
      end
    endcase
  end

  // One shift-add step: {hi,lo} holds partial product above the remaining multiplier bits.
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi_next, mul_lo_next;
  logic [2*XLEN-1:0] prod_mag, prod_s;
  assign mul_sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
  assign mul_hi_next = mul_sum[XLEN:1];
  assign mul_lo_next = {mul_sum[0], lo_reg[XLEN-1:1]};
  assign prod_mag    = {mul_hi_next, mul_lo_next};
  assign prod_s      = neg_reg ? -prod_mag : prod_mag;

  // One restoring-division step: hi is the partial remainder, lo shifts dividend out / quotient in.
  logic [XLEN:0]   div_shift, div_diff;
  logic            div_ok;
  logic [XLEN-1:0] div_hi_next, div_lo_next, quo_s, rem_s, final_res;
  assign div_shift   = {hi_reg, lo_reg[XLEN-1]};
  assign div_diff    = div_shift - {1'b0, b_reg};
  assign div_ok      = !div_diff[XLEN];
  assign div_hi_next = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign div_lo_next = {lo_reg[XLEN-2:0], div_ok};
  assign quo_s       = neg_reg ? -div_lo_next : div_lo_next;
  assign rem_s       = rneg_reg ? -div_hi_next : div_hi_next;

  always_comb begin
    if (state_reg == ST_DIV)
      final_res = op_reg[1] ? rem_s : quo_s;
    else
      final_res = (op_reg == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      b_reg         <= '0;
      neg_reg       <= 1'b0;
      rneg_reg      <= 1'b0;
      op_reg        <= 2'b00;
      out_valid_reg <= 1'b0;
      taken_reg     <= 1'b0;
      alu_out_reg   <= '0;
      addr_reg      <= '0;
      pc_reg        <= '0;
      tag_reg       <= '0;
    end else if (Flush) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      pc_reg   <= PC_EX;
      tag_reg  <= Rd_Tag;
      addr_reg <= {addr_sum[XLEN-1:1], addr_sum[0] & !I_Type_JAL_R};
      if (is_m && !special) begin
        state_reg     <= is_div ? ST_DIV : ST_MUL;
        cnt_reg       <= '0;
        hi_reg        <= '0;
        lo_reg        <= is_div ? mag1 : mag2;
        b_reg         <= is_div ? mag2 : mag1;
        neg_reg       <= neg1 ^ neg2;
        rneg_reg      <= neg1;
        op_reg        <= Alu_Ctrl[1:0];
        out_valid_reg <= 1'b0;
        taken_reg     <= 1'b0;
      end else begin
        alu_out_reg   <= single_res;
        taken_reg     <= single_taken;
        out_valid_reg <= 1'b1;
      end
    end else if (state_reg != ST_IDLE) begin
      cnt_reg <= cnt_reg + SHW'(1);
      hi_reg  <= (state_reg == ST_DIV) ? div_hi_next : mul_hi_next;
      lo_reg  <= (state_reg == ST_DIV) ? div_lo_next : mul_lo_next;
      if (cnt_reg == SHW'(XLEN-1)) begin
        state_reg     <= ST_IDLE;
        alu_out_reg   <= final_res;
        out_valid_reg <= 1'b1;
      end
    end else if (Out_Ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign Out_Valid       = out_valid_reg;
  assign Alu_Out         = alu_out_reg;
  assign Address_Out     = addr_reg;
  assign Is_Branch_Taken = taken_reg;
  assign PC_Out          = pc_reg;
  assign Rd_Tag_Out      = tag_reg;

endmodule

// File: tb/tb_stage_3_mc_exec.sv
// Directed bench for stage_3_mc_exec: ALU, branches, M ops, hold, flush and reset abort.
module tb_stage_3_mc_exec;
  logic        Clk = 1'b0, Rst_n = 1'b0, Flush = 1'b0, In_Valid = 1'b0, Out_Ready = 1'b1;
  logic        J_Type = 1'b0, I_Type_JAL_R = 1'b0;
  logic [31:0] PC_EX = '0, Operand1_ACU = '0, Operand2_ACU = '0, Operand1_DEU = '0, Operand2_DEU = '0;
  logic [4:0]  Alu_Ctrl = '0, Rd_Tag = '0;
  logic        In_Ready, Out_Valid, Is_Branch_Taken, Busy;
  logic [31:0] Alu_Out, Address_Out, PC_Out;
  logic [4:0]  Rd_Tag_Out;

  int errors = 0, checks = 0;
  logic [31:0] pc_ctr = 32'h100;

  stage_3_mc_exec #(.XLEN(32), .TAG_W(5), .ENABLE_M(1'b1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .PC_EX(PC_EX), .Operand1_ACU(Operand1_ACU), .Operand2_ACU(Operand2_ACU),
    .Operand1_DEU(Operand1_DEU), .Operand2_DEU(Operand2_DEU), .Alu_Ctrl(Alu_Ctrl),
    .J_Type(J_Type), .I_Type_JAL_R(I_Type_JAL_R), .Rd_Tag(Rd_Tag),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Alu_Out(Alu_Out), .Address_Out(Address_Out),
    .Is_Branch_Taken(Is_Branch_Taken), .PC_Out(PC_Out), .Rd_Tag_Out(Rd_Tag_Out), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] ctrl, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] a1, input logic [31:0] a2, input logic jr);
    pc_ctr       = pc_ctr + 32'd4;
    PC_EX        = pc_ctr;
    Rd_Tag       = pc_ctr[6:2];
    Alu_Ctrl     = ctrl;
    Operand1_DEU = d1;
    Operand2_DEU = d2;
    Operand1_ACU = a1;
    Operand2_ACU = a2;
    I_Type_JAL_R = jr;
    J_Type       = 1'b0;
    In_Valid     = 1'b1;
  endtask

  // Single-cycle op: result must appear the cycle after acceptance.
  task automatic single_op(input string tag, input logic [4:0] ctrl, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] a1, input logic [31:0] a2,
                           input logic jr, input logic [31:0] exp_alu, input logic exp_taken,
                           input logic [31:0] exp_addr);
    logic [31:0] pc_exp;
    drive(ctrl, d1, d2, a1, a2, jr);
    pc_exp = pc_ctr;
    #1;
    check({tag, "_in_ready"}, {31'b0, In_Ready}, 32'd1);
    step();
    check({tag, "_out_valid"}, {31'b0, Out_Valid}, 32'd1);
    check({tag, "_alu_out"}, Alu_Out, exp_alu);
    check({tag, "_taken"}, {31'b0, Is_Branch_Taken}, {31'b0, exp_taken});
    check({tag, "_addr"}, Address_Out, exp_addr);
    check({tag, "_pc"}, PC_Out, pc_exp);
    check({tag, "_tag"}, {27'b0, Rd_Tag_Out}, {27'b0, pc_exp[6:2]});
    $display("op %s alu=0x%08h taken=%0b addr=0x%08h", tag, Alu_Out, Is_Branch_Taken, Address_Out);
  endtask

  // M op: measure latency from the accept cycle, busy cycles and In_Ready while busy.
  task automatic m_op(input string tag, input logic [4:0] ctrl, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [31:0] exp_res, input int exp_lat,
                      input int exp_busy);
    int lat, busy_cnt, ir_bad;
    logic [31:0] pc_exp;
    drive(ctrl, d1, d2, 32'h0, 32'h0, 1'b0);
    pc_exp = pc_ctr;
    #1;
    check({tag, "_in_ready"}, {31'b0, In_Ready}, 32'd1);
    step();
    In_Valid = 1'b0;
    lat = 1; busy_cnt = 0; ir_bad = 0;
    while (Out_Valid !== 1'b1 && lat < 100) begin
      if (Busy) busy_cnt++;
      if (In_Ready) ir_bad++;
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    check({tag, "_in_ready_busy"}, ir_bad, 0);
    check({tag, "_result"}, Alu_Out, exp_res);
    check({tag, "_taken"}, {31'b0, Is_Branch_Taken}, 32'd0);
    check({tag, "_pc"}, PC_Out, pc_exp);
    check({tag, "_busy_end"}, {31'b0, Busy}, 32'd0);
    $display("op %s result=0x%08h latency=%0d busy=%0d", tag, Alu_Out, lat, busy_cnt);
  endtask

  initial begin
    int held_bad, ov_cnt;
    logic [31:0] pc_hold;

    // Reset
    step();
    step();
    check("rst_out_valid", {31'b0, Out_Valid}, 32'd0);
    check("rst_alu_out", Alu_Out, 32'd0);
    check("rst_addr", Address_Out, 32'd0);
    check("rst_taken", {31'b0, Is_Branch_Taken}, 32'd0);
    check("rst_pc", PC_Out, 32'd0);
    check("rst_tag", {27'b0, Rd_Tag_Out}, 32'd0);
    check("rst_busy", {31'b0, Busy}, 32'd0);
    Rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'b0, In_Ready}, 32'd1);
    $display("reset released");

    // Back-to-back ALU ops
    single_op("add", 5'b00000, 32'd7, 32'hFFFF_FFFD, 32'h10, 32'h20, 1'b0, 32'd4, 1'b0, 32'h30);
    single_op("sra", 5'b01101, 32'h8000_0000, 32'd4, 32'h0, 32'h0, 1'b0, 32'hF800_0000, 1'b0, 32'h0);
    single_op("sub", 5'b01000, 32'd5, 32'd9, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0);
    single_op("sltu", 5'b00011, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 32'd1, 1'b0, 32'h0);

    // Branches and JALR
    single_op("blt", 5'b10100, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 1'b0, 32'd0, 1'b1, 32'h0);
    single_op("bltu", 5'b10110, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0, 32'h0);
    single_op("jalr", 5'b01001, 32'h0, 32'h0, 32'h1001, 32'h4, 1'b1, 32'd0, 1'b1, 32'h1004);
    In_Valid = 1'b0;
    I_Type_JAL_R = 1'b0;
    step();

    // Multiply / divide
    m_op("mulh", 5'b11001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 32);
    m_op("mulhu", 5'b11011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 32);
    m_op("mul", 5'b11000, 32'hFFFF_FFFD, 32'd6, 32'hFFFF_FFEE, 33, 32);
    m_op("div", 5'b11100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 32);
    m_op("rem", 5'b11110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 32);
    m_op("divu0", 5'b11101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    m_op("divovf", 5'b11100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    step();

    // Hold: consumer stalls for 5 cycles
    single_op("add_hold", 5'b00000, 32'd10, 32'd20, 32'h0, 32'h0, 1'b0, 32'd30, 1'b0, 32'h0);
    pc_hold = PC_Out;
    Out_Ready = 1'b0;
    drive(5'b01000, 32'd50, 32'd8, 32'h0, 32'h0, 1'b0);
    held_bad = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (In_Ready !== 1'b0 || Out_Valid !== 1'b1 || Alu_Out !== 32'd30 || PC_Out !== pc_hold)
        held_bad++;
      step();
    end
    check("hold_stable", held_bad, 0);
    Out_Ready = 1'b1;
    #1;
    check("hold_release_in_ready", {31'b0, In_Ready}, 32'd1);
    step();
    check("hold_next_result", Alu_Out, 32'd42);
    check("hold_next_valid", {31'b0, Out_Valid}, 32'd1);
    check("hold_next_pc", PC_Out, pc_ctr);
    $display("op hold released, next result=0x%08h", Alu_Out);
    In_Valid = 1'b0;
    step();

    // Flush during DIVU
    drive(5'b11101, 32'd100, 32'd3, 32'h0, 32'h0, 1'b0);
    step();
    In_Valid = 1'b0;
    for (int k = 0; k < 9; k++) step();
    check("flush_busy_before", {31'b0, Busy}, 32'd1);
    Flush = 1'b1;
    drive(5'b00000, 32'd1, 32'd1, 32'h0, 32'h0, 1'b0);
    #1;
    check("flush_in_ready", {31'b0, In_Ready}, 32'd0);
    step();
    Flush = 1'b0;
    In_Valid = 1'b0;
    check("flush_busy_after", {31'b0, Busy}, 32'd0);
    ov_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (Out_Valid) ov_cnt++;
      step();
    end
    check("flush_no_out_valid", ov_cnt, 0);
    $display("op divu flushed");

    // Reset pulse during MUL
    drive(5'b11000, 32'd3, 32'd5, 32'h0, 32'h0, 1'b0);
    step();
    In_Valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    Rst_n = 1'b0;
    #1;
    check("rstmid_busy", {31'b0, Busy}, 32'd0);
    check("rstmid_alu_out", Alu_Out, 32'd0);
    step();
    Rst_n = 1'b1;
    ov_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (Out_Valid) ov_cnt++;
      step();
    end
    check("rstmid_no_out_valid", ov_cnt, 0);
    $display("op mul aborted by reset");

    single_op("add_after", 5'b00000, 32'd1, 32'd2, 32'h0, 32'h0, 1'b0, 32'd3, 1'b0, 32'h0);
    In_Valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stage_3_mc_exec.md
Name: stage_3_mc_exec

Overview:
Parametrised, multi-cycle successor to the single-cycle execute stage. It combines the RV32I ALU, branch comparator and address unit with an iterative RV M-extension multiplier/divider. Every result is registered behind a valid/ready handshake, and Busy stalls the decode stage while an iterative op runs. It sits between the ID/EX operand-forwarding muxes and the EX/MEM register.

Parameters:
XLEN, 32, datapath width (≥8, even)
TAG_W, 5, width of the destination-register tag carried alongside the op
ENABLE_M, 1, 1 = 11xxx codes execute M ops; 0 = 11xxx codes treated as undefined

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  reset, asynchronous and active-low
Flush  in  1  synchronous abort of in-flight op and held result
In_Valid  in  1  operands/control valid
In_Ready  out  1  unit accepts op this cycle
PC_EX  in  XLEN  PC of op, carried to PC_Out
Operand1_ACU  in  XLEN  address-unit operand 1
Operand2_ACU  in  XLEN  address-unit operand 2
Operand1_DEU  in  XLEN  data-ALU operand 1
Operand2_DEU  in  XLEN  data-ALU operand 2
Alu_Ctrl  in  5  op code
J_Type  in  1  JAL
I_Type_JAL_R  in  1  JALR
Rd_Tag  in  TAG_W  destination tag
Out_Valid  out  1  result registered and valid
Out_Ready  in  1  consumer takes result
Alu_Out  out  XLEN  data result
Address_Out  out  XLEN  Operand1_ACU+Operand2_ACU; bit 0 cleared when I_Type_JAL_R
Is_Branch_Taken  out  1  branch/jump decision
PC_Out  out  XLEN  registered PC_EX
Rd_Tag_Out  out  TAG_W  registered Rd_Tag
Busy  out  1  iterative op in progress

Behaviour:
- Reset: state IDLE; Out_Valid, Alu_Out, Address_Out, Is_Branch_Taken, PC_Out, Rd_Tag_Out, Busy = 0. In_Ready = 1 once Rst_n deasserts.
- Accept: fires when In_Valid && In_Ready.
- In_Ready = (state==IDLE) && (!Out_Valid || Out_Ready) && !Flush. This is combinational.
- ALU codes, same meaning as the current EX stage: 00000 ADD, 01000 SUB, 00001 SLL, 00010 SLT, 00011 SLTU, 00100 XOR, 00101 SRL, 01101 SRA, 00110 OR, 00111 AND.
  - Shift amount is Operand2_DEU[log2(XLEN)-1:0].
- Branch codes: 10000 BEQ, 10001 BNE, 10100 BLT, 10101 BGE, 10110 BLTU, 10111 BGEU. Alu_Out = 0.
- Is_Branch_Taken:
  - Branch codes: comparator result.
  - Defined ALU codes and M codes: 0.
  - All other codes: J_Type | I_Type_JAL_R.
- Single-cycle ops (ALU, branch, undefined):
  - Result registered at the accept edge; Out_Valid = 1 the next cycle (latency 1).
  - Throughput is 1 per cycle while Out_Ready = 1.
- M codes (ENABLE_M=1): 11000 MUL, 11001 MULH, 11010 MULHSU, 11011 MULHU, 11100 DIV, 11101 DIVU, 11110 REM, 11111 REMU.
- FSM states: IDLE, MUL, DIV.
  - IDLE → MUL/DIV on accept of an M code.
  - MUL/DIV run XLEN iterations, then load the output register and return to IDLE.
  - Out_Valid rises XLEN+1 cycles after the accept edge.
  - Busy = (state != IDLE).
- Multiply:
  - Shift-add on operand magnitudes into a 2·XLEN product, sign-corrected at completion.
  - Signedness: MULH signed×signed; MULHSU signed×unsigned; MULHU unsigned×unsigned.
  - MUL returns low XLEN bits; the others return high XLEN bits.
- Divide: restoring division on magnitudes.
  - Quotient sign = sign(op1) XOR sign(op2).
  - Remainder sign = sign(op1).
- Divide special cases complete in 1 cycle and do not enter DIV:
  - Divisor 0: DIV/DIVU = all ones; REM/REMU = op1.
  - Signed overflow (op1 = −2^(XLEN−1), op2 = −1): DIV = op1; REM = 0.
- Address_Out, PC_Out and Rd_Tag_Out are captured at accept for every op and remain valid for M ops.
- Hold: while Out_Valid && !Out_Ready, all outputs stay stable and no new op is accepted.
- Flush (priority over everything except reset), next edge:
  - Out_Valid = 0; state = IDLE.
  - The iteration is abandoned and any op presented that cycle is dropped.
- Rst_n low mid-iteration: immediate return to reset state; no partial result is ever presented.
- Undefined codes with ENABLE_M=0 or unlisted 0xxxx codes: Alu_Out = 0, latency 1.

Test Plan:
- Reset, then ADD 7+(−3) and SRA 0x80000000>>>4 back-to-back with Out_Ready=1 → Alu_Out 4 then 0xF8000000 on consecutive cycles; In_Ready stays 1.
- BLT −1 vs 1, then BLTU 0xFFFFFFFF vs 1, then JALR with ACU 0x1001+0x4 → Is_Branch_Taken 1, 0, 1; JALR Address_Out 0x1004.
- MULH 0x80000000×0x80000000 and MULHU 0xFFFFFFFF×0xFFFFFFFF → 0x40000000 and 0xFFFFFFFE, each 33 cycles after accept; Busy high for 32 cycles, In_Ready low meanwhile.
- DIV −7/2, REM −7/2, DIVU 5/0, DIV 0x80000000/−1 → 0xFFFFFFFD (33 cycles), 0xFFFFFFFF (33 cycles), 0xFFFFFFFF (1 cycle), 0x80000000 (1 cycle).
- Out_Ready held low 5 cycles after ADD result → outputs stable, In_Ready 0; release → next op accepted the same cycle Out_Ready rises.
- Flush at cycle 10 of DIVU, and Rst_n pulse mid-MUL → no Out_Valid for either op; next ADD completes normally with latency 1.
